btb_predictor: RTL and testbench

- Fully-associative branch target buffer with per-entry 2-bit bimodal counters, sitting in the fetch stage beside the instruction cache request path.
- Fetch presents the next fetch PC; one cycle later the block returns a taken/not-taken prediction and a target, used to steer the following fetch PC.
- Execute sends resolved branch/jump outcomes back on an update port to train the table.

---
 rtl/btb_predictor.sv | 139 +++++++++++++
 tb/tb_btb_predictor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// Fully-associative branch target buffer with per-entry 2-bit bimodal
// counters. Lookups return one cycle after the request; execute-stage
// updates train or allocate entries, and flush invalidates the whole table.
module btb_predictor #(
  parameter int unsigned ENTRIES     = 8,
  parameter int unsigned OPAQUE_BITS = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [31:0]            req_addr,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic                   resp_taken,
  output logic [31:0]            resp_target,
  output logic [OPAQUE_BITS-1:0] resp_entry,
  output logic [1:0]             resp_ctr,
  input  logic                   upd_valid,
  input  logic [31:0]            upd_pc,
  input  logic [31:0]            upd_target,
  input  logic                   upd_taken,
  input  logic                   upd_is_br,
  input  logic                   flush
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [29:0]        tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic               is_br  [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr;

  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;
  logic             up_hit;
  logic [IDX_W-1:0] up_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] victim;
  logic [1:0]       ctr_old;
  logic [1:0]       ctr_nxt;
  logic             do_upd;
  logic             do_alloc;

  // Word-aligned PCs only; the low address bits carry no information here.
  logic unused_low_bits;
  assign unused_low_bits = ^{req_addr[1:0], upd_pc[1:0]};

  // Associative match for both the fetch lookup and the update port, plus
  // lowest-free-slot search for allocation.
  always_comb begin
    lk_hit     = 1'b0;
    lk_idx     = '0;
    up_hit     = 1'b0;
    up_idx     = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tag[i] == req_addr[31:2]) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (valid[i] && tag[i] == upd_pc[31:2]) begin
        up_hit = 1'b1;
        up_idx = IDX_W'(i);
      end
      if (!valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Update decode: saturating counter step, victim choice; flush drops updates.
  always_comb begin
    do_upd   = upd_valid && !flush && up_hit;
    do_alloc = upd_valid && !flush && !up_hit && upd_taken;
    victim   = free_found ? free_idx : rr_ptr;
    ctr_old  = ctr[up_idx];
    ctr_nxt  = ctr_old;
    if (upd_taken) begin
      if (ctr_old != 2'b11) ctr_nxt = ctr_old + 2'd1;
    end else begin
      if (ctr_old != 2'b00) ctr_nxt = ctr_old - 2'd1;
    end
  end

  // Valid bits and replacement pointer; rr_ptr only moves when a valid entry is evicted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      valid  <= '0;
      rr_ptr <= '0;
    end else if (do_alloc) begin
      valid[victim] <= 1'b1;
      if (!free_found) rr_ptr <= rr_ptr + 1'b1;
    end
  end

  // Entry payload storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (do_upd) begin
      if (upd_is_br) ctr[up_idx] <= ctr_nxt;
      if (upd_taken) begin
        target[up_idx] <= upd_target;
        is_br[up_idx]  <= upd_is_br;
      end
    end else if (do_alloc) begin
      tag[victim]    <= upd_pc[31:2];
      target[victim] <= upd_target;
      is_br[victim]  <= upd_is_br;
      ctr[victim]    <= 2'b10;
    end
  end

  // Registered lookup response, built from pre-update table state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_taken  <= 1'b0;
      resp_target <= '0;
      resp_entry  <= '0;
      resp_ctr    <= '0;
    end else begin
      resp_valid  <= req_valid;
      resp_hit    <= req_valid && lk_hit;
      resp_taken  <= req_valid && lk_hit && (!is_br[lk_idx] || ctr[lk_idx][1]);
      resp_target <= (req_valid && lk_hit) ? target[lk_idx] : '0;
      resp_entry  <= (req_valid && lk_hit) ? OPAQUE_BITS'(lk_idx) : '0;
      resp_ctr    <= (req_valid && lk_hit) ? ctr[lk_idx] : '0;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: reset state, allocation, counter
// training, jumps, round-robin replacement, read-before-write and flush.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_hit;
  logic        resp_taken;
  logic [31:0] resp_target;
  logic [9:0]  resp_entry;
  logic [1:0]  resp_ctr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_is_br;
  logic        flush;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  btb_predictor #(.ENTRIES(8), .OPAQUE_BITS(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_taken  (resp_taken),
    .resp_target (resp_target),
    .resp_entry  (resp_entry),
    .resp_ctr    (resp_ctr),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .upd_is_br   (upd_is_br),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Advance one clock; inputs and outputs are handled 1ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input string tag, input logic hit, input logic taken,
                             input logic [31:0] tgt, input logic [9:0] entry,
                             input logic [1:0] c);
    check({tag, ".valid"},  {31'd0, resp_valid}, 32'd1);
    check({tag, ".hit"},    {31'd0, resp_hit},   {31'd0, hit});
    check({tag, ".taken"},  {31'd0, resp_taken}, {31'd0, taken});
    check({tag, ".target"}, resp_target,         tgt);
    check({tag, ".entry"},  {22'd0, resp_entry}, {22'd0, entry});
    check({tag, ".ctr"},    {30'd0, resp_ctr},   {30'd0, c});
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                     input logic taken, input logic isbr);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = taken;
    upd_is_br  = isbr;
    cycle();
    upd_valid  = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] addr);
    req_valid = 1'b1;
    req_addr  = addr;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_target = '0;
    upd_taken  = 1'b0;
    upd_is_br  = 1'b0;
    flush      = 1'b0;
    #2;
    check("rst.valid",  {31'd0, resp_valid}, 32'd0);
    check("rst.hit",    {31'd0, resp_hit},   32'd0);
    check("rst.target", resp_target,         32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Cold lookup misses.
    lookup(32'h100);
    expect_resp("cold", 1'b0, 1'b0, 32'h0, 10'd0, 2'd0);

    // Allocate a taken branch: weakly taken in entry 0.
    upd(32'h100, 32'h200, 1'b1, 1'b1);
    lookup(32'h100);
    expect_resp("alloc", 1'b1, 1'b1, 32'h200, 10'd0, 2'd2);
    // Idle cycle returns all zeros.
    cycle();
    check("idle.valid", {31'd0, resp_valid}, 32'd0);
    check("idle.hit",   {31'd0, resp_hit},   32'd0);
    check("idle.target", resp_target,        32'd0);

    // Train down to strongly not-taken; entry stays valid.
    upd(32'h100, 32'h0, 1'b0, 1'b1);
    lookup(32'h100);
    expect_resp("nt1", 1'b1, 1'b0, 32'h200, 10'd0, 2'd1);
    upd(32'h100, 32'h0, 1'b0, 1'b1);
    lookup(32'h100);
    expect_resp("nt2", 1'b1, 1'b0, 32'h200, 10'd0, 2'd0);
    upd(32'h100, 32'h0, 1'b0, 1'b1);
    lookup(32'h100);
    expect_resp("nt_sat", 1'b1, 1'b0, 32'h200, 10'd0, 2'd0);

    // Train up and saturate at 3.
    upd(32'h100, 32'h200, 1'b1, 1'b1);
    lookup(32'h100);
    expect_resp("t1", 1'b1, 1'b0, 32'h200, 10'd0, 2'd1);
    upd(32'h100, 32'h200, 1'b1, 1'b1);
    lookup(32'h100);
    expect_resp("t2", 1'b1, 1'b1, 32'h200, 10'd0, 2'd2);
    upd(32'h100, 32'h200, 1'b1, 1'b1);
    lookup(32'h100);
    expect_resp("t3", 1'b1, 1'b1, 32'h200, 10'd0, 2'd3);
    upd(32'h100, 32'h240, 1'b1, 1'b1);
    lookup(32'h100);
    expect_resp("t_sat", 1'b1, 1'b1, 32'h240, 10'd0, 2'd3);

    // Unconditional jump goes to the lowest free entry, always predicted taken.
    upd(32'h300, 32'h380, 1'b1, 1'b0);
    lookup(32'h300);
    expect_resp("jump", 1'b1, 1'b1, 32'h380, 10'd1, 2'd2);

    // Not-taken miss allocates nothing.
    upd(32'h104, 32'h500, 1'b0, 1'b1);
    lookup(32'h104);
    expect_resp("nt_miss", 1'b0, 1'b0, 32'h0, 10'd0, 2'd0);

    // Fill the table, then round-robin replacement from entry 0.
    do_flush();
    for (int unsigned k = 0; k < 8; k++)
      upd(32'h1000 + 4 * k, 32'h8000 + k, 1'b1, 1'b1);
    lookup(32'h101C);
    expect_resp("fill7", 1'b1, 1'b1, 32'h8007, 10'd7, 2'd2);
    upd(32'h2000, 32'h9000, 1'b1, 1'b1);
    lookup(32'h2000);
    expect_resp("repl0", 1'b1, 1'b1, 32'h9000, 10'd0, 2'd2);
    lookup(32'h1000);
    expect_resp("evict0", 1'b0, 1'b0, 32'h0, 10'd0, 2'd0);
    upd(32'h2004, 32'h9004, 1'b1, 1'b1);
    lookup(32'h2004);
    expect_resp("repl1", 1'b1, 1'b1, 32'h9004, 10'd1, 2'd2);
    lookup(32'h1004);
    expect_resp("evict1", 1'b0, 1'b0, 32'h0, 10'd0, 2'd0);
    upd(32'h2008, 32'h9008, 1'b1, 1'b1);
    lookup(32'h2008);
    expect_resp("repl2", 1'b1, 1'b1, 32'h9008, 10'd2, 2'd2);

    // Same-cycle update and request: request sees the old (empty) state.
    do_flush();
    req_valid = 1'b1;
    req_addr  = 32'h100;
    upd(32'h100, 32'h200, 1'b1, 1'b1);
    expect_resp("rbw_same", 1'b0, 1'b0, 32'h0, 10'd0, 2'd0);
    cycle();
    req_valid = 1'b0;
    expect_resp("rbw_next", 1'b1, 1'b1, 32'h200, 10'd0, 2'd2);

    // Flush wins over a same-cycle update; same-cycle request sees pre-flush state.
    req_valid  = 1'b1;
    req_addr   = 32'h100;
    flush      = 1'b1;
    upd(32'h400, 32'h440, 1'b1, 1'b1);
    flush      = 1'b0;
    req_valid  = 1'b0;
    expect_resp("flush_same", 1'b1, 1'b1, 32'h200, 10'd0, 2'd2);
    lookup(32'h100);
    expect_resp("flush_100", 1'b0, 1'b0, 32'h0, 10'd0, 2'd0);
    lookup(32'h400);
    expect_resp("flush_400", 1'b0, 1'b0, 32'h0, 10'd0, 2'd0);

    // Asynchronous reset mid-stream clears resp_valid without a clock edge.
    req_valid = 1'b1;
    req_addr  = 32'h100;
    cycle();
    check("pre_rst.valid", {31'd0, resp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.valid", {31'd0, resp_valid}, 32'd0);
    req_valid = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
